// File: rtl/gf_div.sv
// GF(2^163) divider, Q = A * B^-1 mod F, F = x^163 + x^7 + x^6 + x^3 + 1.
// Binary extended-Euclid, one reduction step per clock, start/done handshake.
module gf_div #(
  parameter int NUM_BITS = 163
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_BITS:0] A,
  input  logic [NUM_BITS:0] B,
  input  logic              start,
  output logic [NUM_BITS:0] Q,
  output logic              done
);

  localparam logic [NUM_BITS:0] F_POLY = {1'b1, {(NUM_BITS-8){1'b0}}, 8'hC9};
  localparam logic [NUM_BITS:0] ONE    = {{NUM_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_BITS:0] u_q, u_d;
  logic [NUM_BITS:0] v_q, v_d;
  logic [NUM_BITS:0] x_q, x_d;
  logic [NUM_BITS:0] y_q, y_d;
  logic [NUM_BITS:0] res_q, res_d;
  logic [NUM_BITS:0] q_d;
  logic              done_d;

  // Divide a reduced element by x: add F first when the constant term is set,
  // so the shifted-out bit is always zero.
  function automatic logic [NUM_BITS:0] half_mod(input logic [NUM_BITS:0] p);
    if (p[0])
      return (p ^ F_POLY) >> 1;
    else
      return p >> 1;
  endfunction

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    q_d     = Q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          u_d = B;
          v_d = F_POLY;
          x_d = A;
          y_d = '0;
          if (B == '0) begin
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (u_q == ONE) begin
          res_d   = x_q;
          state_d = S_DONE;
        end else if (v_q == ONE) begin
          res_d   = y_q;
          state_d = S_DONE;
        end else if (!u_q[0]) begin
          u_d = u_q >> 1;
          x_d = half_mod(x_q);
        end else if (!v_q[0]) begin
          v_d = v_q >> 1;
          y_d = half_mod(y_q);
        end else if (u_q >= v_q) begin
          // Numeric order matches degree order closely enough to keep both
          // operands shrinking; either choice preserves the invariants.
          u_d = u_q ^ v_q;
          x_d = x_q ^ y_q;
        end else begin
          v_d = v_q ^ u_q;
          y_d = y_q ^ x_q;
        end
      end

      S_DONE: begin
        q_d     = res_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      Q       <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      Q       <= q_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_gf_div.sv
// Self-checking bench for gf_div: results are checked by multiplying back
// (Q*B mod F == A) with a shift-and-add field multiplier.
module tb_gf_div;

  localparam int NB = 163;
  localparam logic [NB:0] F_POLY = {1'b1, {(NB-8){1'b0}}, 8'hC9};

  logic          clk   = 1'b0;
  logic          n_rst = 1'b1;
  logic          start = 1'b0;
  logic [NB:0]   A     = '0;
  logic [NB:0]   B     = '0;
  logic [NB:0]   Q;
  logic          done;

  int checks = 0;
  int errors = 0;

  gf_div #(.NUM_BITS(NB)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .A    (A),
    .B    (B),
    .start(start),
    .Q    (Q),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic logic [NB:0] gf_mul(input logic [NB:0] a, input logic [NB:0] b);
    logic [NB:0] r;
    r = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[NB]) r = r ^ F_POLY;
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [NB:0] rand_elem();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return {1'b0, t[NB-1:0]};
  endfunction

  // Drives one operation; lat counts clock edges from the start edge up to and
  // including the edge that raised done. Inputs are scrambled after start.
  task automatic run_op(input logic [NB:0] a, input logic [NB:0] b,
                        output int lat, output logic [NB:0] q,
                        output bit ok, output bit one_wide);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = rand_elem();
    B = rand_elem();
    lat = 1;
    ok = 1'b0;
    while (lat < 700) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    q = Q;
    @(posedge clk); #1;
    one_wide = (done === 1'b0) && (Q === q);
  endtask

  task automatic test_reset();
    #3 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Q !== '0) begin
      errors++;
      $display("FAIL reset_q: got %h want 0", Q);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_known();
    int          lat;
    logic [NB:0] q, a, e;
    bit          ok, w;

    run_op(1, 1, lat, q, ok, w);
    checks++;
    if (!ok || q !== 1) begin
      errors++;
      $display("FAIL one_over_one: got %h ok=%0d want 1", q, ok);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL one_latency: got %0d want 3", lat);
    end

    e = '0; e[162] = 1'b1; e[6] = 1'b1; e[5] = 1'b1; e[2] = 1'b1;
    run_op(1, 2, lat, q, ok, w);
    checks++;
    if (!ok || q !== e) begin
      errors++;
      $display("FAIL inv_x: got %h want %h", q, e);
    end

    a = '0; a[162] = 1'b1; a[161] = 1'b1; a[7] = 1'b1; a[6] = 1'b1; a[3] = 1'b1; a[0] = 1'b1;
    run_op(a, 60, lat, q, ok, w);
    checks++;
    if (!ok || q[NB] !== 1'b0 || gf_mul(q, 60) !== a) begin
      errors++;
      $display("FAIL vec_b60: got q=%h q*b=%h want %h", q, gf_mul(q, 60), a);
    end
    checks++;
    if (lat > 656) begin
      errors++;
      $display("FAIL vec_b60_latency: got %0d want <=656", lat);
    end

    run_op(0, rand_elem() | 1, lat, q, ok, w);
    checks++;
    if (!ok || q !== '0) begin
      errors++;
      $display("FAIL zero_dividend: got %h want 0", q);
    end

    run_op(5, 0, lat, q, ok, w);
    checks++;
    if (!ok || q !== '0) begin
      errors++;
      $display("FAIL div_by_zero: got %h want 0", q);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL div_by_zero_latency: got %0d want 2", lat);
    end
    checks++;
    if (!w) begin
      errors++;
      $display("FAIL div_by_zero_pulse: done not a single-cycle pulse");
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [NB:0] a, b, q;
    bit          ok, w;
    for (int n = 0; n < 100; n++) begin
      a = rand_elem();
      do b = rand_elem(); while (b == '0);
      run_op(a, b, lat, q, ok, w);
      checks++;
      if (!ok || q[NB] !== 1'b0 || gf_mul(q, b) !== a) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h got q=%h q*b=%h", n, a, b, q, gf_mul(q, b));
      end
      checks++;
      if (lat > 656 || !w) begin
        errors++;
        $display("FAIL random_timing_%0d: latency %0d (max 656) single_pulse=%0d", n, lat, w);
      end
    end
  endtask

  task automatic test_busy_start();
    logic [NB:0] a, b;
    int          lat, extra;
    bit          ok;
    for (int n = 0; n < 3; n++) begin
      a = rand_elem();
      b = rand_elem() | {2'b01, {(NB-1){1'b0}}};
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      A = rand_elem(); B = rand_elem() | 1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 3; ok = 1'b0;
      while (lat < 700) begin
        if (done === 1'b1) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (!ok || gf_mul(Q, b) !== a) begin
        errors++;
        $display("FAIL busy_start_%0d: got q=%h q*b=%h want %h", n, Q, gf_mul(Q, b), a);
      end
      extra = 0;
      repeat (700) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
        errors++;
        $display("FAIL busy_extra_done_%0d: got %0d extra pulses want 0", n, extra);
      end
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [NB:0] a, b, q;
    bit          ok, w;
    a = rand_elem();
    b = rand_elem() | {2'b01, {(NB-1){1'b0}}};
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if (Q !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got q=%h done=%b want 0/0", Q, done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || Q !== '0) begin
      errors++;
      $display("FAIL reset_abort: got q=%h done=%b want 0/0", Q, done);
    end
    a = rand_elem();
    b = rand_elem() | 1;
    run_op(a, b, lat, q, ok, w);
    checks++;
    if (!ok || gf_mul(q, b) !== a) begin
      errors++;
      $display("FAIL after_reset: got q=%h q*b=%h want %h", q, gf_mul(q, b), a);
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_random();
    test_busy_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
